// File: rtl/dilithium_host_ctrl.sv
// Host-side sequencer for the Dilithium core: command -> start pulse -> stream in/out -> done -> status.
// Optional stall watchdog is built only when DILITHIUM_HOST_TIMEOUT_EN is defined.
module dilithium_host_ctrl #(
  parameter int W          = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_in_words,
  input  logic [CNT_W-1:0] cmd_out_words,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [W-1:0]     src_data,
  output logic             sink_valid,
  input  logic             sink_ready,
  output logic [W-1:0]     sink_data,
  output logic             busy,
  output logic             status_valid,
  output logic             status_err,
  output logic             core_start,
  output logic [1:0]       core_mode,
  input  logic             core_done,
  output logic             core_valid_i,
  input  logic             core_ready_i,
  output logic [W-1:0]     core_data_i,
  input  logic             core_valid_o,
  output logic             core_ready_o,
  input  logic [W-1:0]     core_data_o,
  output logic [2:0]       dbg_state_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_STREAM    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DRAIN     = 3'd4,
    S_REPORT    = 3'd5
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] in_cnt_q, out_cnt_q;
  logic             core_start_q, status_valid_q;
  logic [1:0]       core_mode_q;
  logic [W-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             streaming, in_hs, push, pop, fifo_empty, fifo_full, flush;

  // Valid/ready: a word moves on any cycle where both are high at the rising edge;
  // the source may hold valid with no ready, and ready never depends on a later valid.
  assign streaming    = (state_q == S_STREAM);
  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == FULL_CNT);
  assign core_valid_i = src_valid && streaming && (in_cnt_q != '0);
  assign src_ready    = core_ready_i && streaming && (in_cnt_q != '0);
  assign core_data_i  = src_data;
  assign in_hs        = src_valid && src_ready;
  assign core_ready_o = streaming && (out_cnt_q != '0) && !fifo_full;
  assign push         = core_valid_o && core_ready_o;
  assign sink_valid   = !fifo_empty;
  assign pop          = sink_valid && sink_ready;
  assign sink_data    = fifo_empty ? '0 : mem_q[rd_ptr_q];

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign core_start   = core_start_q;
  assign core_mode    = core_mode_q;
  assign status_valid = status_valid_q;
  assign dbg_state_o  = state_q;

`ifdef DILITHIUM_HOST_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q;
  logic          status_err_q, advance, timeout_hit;

  assign advance     = (streaming && in_cnt_q == '0 && out_cnt_q == '0) ||
                       (state_q == S_WAIT_DONE && core_done);
  assign timeout_hit = (streaming || state_q == S_WAIT_DONE) && !advance &&
                       !in_hs && !push && !pop && (stall_q == SW'(TIMEOUT - 1));
  assign flush       = timeout_hit;
  assign status_err  = status_err_q;

  // Stall only accumulates while waiting in the two states that can hang on the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (in_hs || push || pop || advance || !(streaming || state_q == S_WAIT_DONE)) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + SW'(1);
    end
  end
`else
  assign flush      = 1'b0;
  assign status_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= core_data_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      core_start_q   <= 1'b0;
      core_mode_q    <= 2'd0;
      status_valid_q <= 1'b0;
`ifdef DILITHIUM_HOST_TIMEOUT_EN
      status_err_q   <= 1'b0;
`endif
    end else begin
      core_start_q   <= 1'b0;
      status_valid_q <= 1'b0;
      if (in_hs) in_cnt_q  <= in_cnt_q - CNT_W'(1);
      if (push)  out_cnt_q <= out_cnt_q - CNT_W'(1);
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          state_q      <= S_START;
          core_mode_q  <= cmd_mode;
          in_cnt_q     <= cmd_in_words;
          out_cnt_q    <= cmd_out_words;
          core_start_q <= 1'b1;
        end
        S_START:     state_q <= S_STREAM;
        S_STREAM:    if (in_cnt_q == '0 && out_cnt_q == '0) state_q <= S_WAIT_DONE;
        S_WAIT_DONE: if (core_done) state_q <= S_DRAIN;
        S_DRAIN: if (fifo_empty) begin
          state_q        <= S_REPORT;
          status_valid_q <= 1'b1;
        end
        S_REPORT: begin
          state_q <= S_IDLE;
`ifdef DILITHIUM_HOST_TIMEOUT_EN
          status_err_q <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef DILITHIUM_HOST_TIMEOUT_EN
      if (timeout_hit) begin
        state_q        <= S_REPORT;
        status_valid_q <= 1'b1;
        status_err_q   <= 1'b1;
        in_cnt_q       <= '0;
        out_cnt_q      <= '0;
      end
`endif
    end
  end
endmodule
